// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes and FSM states.
package muldiv_pkg;

   localparam int unsigned MD_OP_LENGTH = 3;

   typedef logic [MD_OP_LENGTH-1:0] md_op_t;

   // Codes 0 and 7 are unassigned and ignored by the unit.
   localparam md_op_t MdOpMult  = 3'd1;
   localparam md_op_t MdOpMultu = 3'd2;
   localparam md_op_t MdOpDiv   = 3'd3;
   localparam md_op_t MdOpDivu  = 3'd4;
   localparam md_op_t MdOpMthi  = 3'd5;
   localparam md_op_t MdOpMtlo  = 3'd6;

   typedef enum logic [1:0] {
      StIdle,
      StMul,
      StDiv,
      StDone
   } md_state_e;

   function automatic logic md_op_signed(input md_op_t op);
      return (op == MdOpMult) || (op == MdOpDiv);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Issue/result bundle between the EX stage and the multiply/divide unit.
interface muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   import muldiv_pkg::*;

   logic             start_i;
   md_op_t           op_i;
   logic [WIDTH-1:0] src_a_i;
   logic [WIDTH-1:0] src_b_i;
   logic             flush_i;
   logic             busy_o;
   logic             done_o;
   logic             div_by_zero_o;
   logic [WIDTH-1:0] hi_o;
   logic [WIDTH-1:0] lo_o;

   modport master (
      output start_i, op_i, src_a_i, src_b_i, flush_i,
      input  busy_o, done_o, div_by_zero_o, hi_o, lo_o
   );

   modport slave (
      input  start_i, op_i, src_a_i, src_b_i, flush_i,
      output busy_o, done_o, div_by_zero_o, hi_o, lo_o
   );

endinterface

// File: rtl/muldiv_div_core.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per cycle.
// quotient/remainder reflect the state after the step performed in the current cycle.
module muldiv_div_core #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             load,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   // {partial remainder (WIDTH+1), dividend/quotient shift register (WIDTH)}
   logic [2*WIDTH:0] acc_q;
   logic [2*WIDTH:0] acc_d;
   logic [2*WIDTH:0] shifted;
   logic [WIDTH+1:0] diff;
   logic [WIDTH-1:0] divisor_q;

   always_comb begin
      shifted = acc_q << 1;
      diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor_q};
      if (diff[WIDTH+1]) begin
         acc_d = shifted;
      end else begin
         acc_d = {diff[WIDTH:0], shifted[WIDTH-1:0] | {{(WIDTH-1){1'b0}}, 1'b1}};
      end
   end

   always_ff @(posedge clk) begin
      if (load) begin
         acc_q     <= {{(WIDTH+1){1'b0}}, dividend};
         divisor_q <= divisor;
      end else begin
         acc_q     <= acc_d;
      end
   end

   assign quotient  = acc_d[WIDTH-1:0];
   assign remainder = acc_d[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with private HI/LO; shift-add multiplier and FSM live here,
// the restoring divider datapath is in muldiv_div_core.
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int unsigned WIDTH         = 32,
   parameter int unsigned MUL_STEP_BITS = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   muldiv_if.slave  md
);

   localparam int unsigned MulSteps = WIDTH / MUL_STEP_BITS;
   localparam int unsigned CntW     = $clog2(WIDTH + 1);
   localparam int unsigned SumW     = WIDTH + MUL_STEP_BITS;

   md_state_e state_q, state_d;

   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [2*WIDTH-1:0] prod_q, prod_d;
   logic               neg_q, neg_d;
   logic               rem_neg_q, rem_neg_d;
   logic               dbz_q, dbz_d;
   logic [CntW-1:0]    cnt_q, cnt_d;

   logic               a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic               div_load;
   logic [WIDTH-1:0]   div_quo, div_rem;
   logic [WIDTH-1:0]   quo_res, rem_res;

   logic [SumW-1:0]    partial, msum;
   logic [2*WIDTH-1:0] prod_step, prod_res;

   always_comb begin
      a_neg = md_op_signed(md.op_i) & md.src_a_i[WIDTH-1];
      b_neg = md_op_signed(md.op_i) & md.src_b_i[WIDTH-1];
      a_mag = a_neg ? ('0 - md.src_a_i) : md.src_a_i;
      b_mag = b_neg ? ('0 - md.src_b_i) : md.src_b_i;
   end

   // Upper half accumulates mcand * next multiplier digit; the product shifts right each step.
   always_comb begin
      partial   = {{MUL_STEP_BITS{1'b0}}, mcand_q} *
                  {{WIDTH{1'b0}}, prod_q[MUL_STEP_BITS-1:0]};
      msum      = partial + {{MUL_STEP_BITS{1'b0}}, prod_q[2*WIDTH-1:WIDTH]};
      prod_step = {msum, prod_q[WIDTH-1:MUL_STEP_BITS]};
      prod_res  = neg_q ? ('0 - prod_step) : prod_step;
      quo_res   = neg_q ? ('0 - div_quo) : div_quo;
      rem_res   = rem_neg_q ? ('0 - div_rem) : div_rem;
   end

   muldiv_div_core #(
      .WIDTH (WIDTH)
   ) u_div_core (
      .clk       (clk),
      .load      (div_load),
      .dividend  (a_mag),
      .divisor   (b_mag),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_comb begin
      state_d   = state_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      mcand_d   = mcand_q;
      prod_d    = prod_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      dbz_d     = 1'b0;
      cnt_d     = cnt_q;
      div_load  = 1'b0;

      if (md.flush_i) begin
         state_d = StIdle;
      end else begin
         case (state_q)
            StIdle: begin
               if (md.start_i) begin
                  case (md.op_i)
                     MdOpMthi: begin
                        hi_d    = md.src_a_i;
                        state_d = StDone;
                     end
                     MdOpMtlo: begin
                        lo_d    = md.src_a_i;
                        state_d = StDone;
                     end
                     MdOpMult, MdOpMultu: begin
                        mcand_d = a_mag;
                        prod_d  = {{WIDTH{1'b0}}, b_mag};
                        neg_d   = a_neg ^ b_neg;
                        cnt_d   = '0;
                        state_d = StMul;
                     end
                     MdOpDiv, MdOpDivu: begin
                        if (md.src_b_i == '0) begin
                           dbz_d   = 1'b1;
                           state_d = StDone;
                        end else begin
                           div_load  = 1'b1;
                           neg_d     = a_neg ^ b_neg;
                           rem_neg_d = a_neg;
                           cnt_d     = '0;
                           state_d   = StDiv;
                        end
                     end
                     default: state_d = StIdle;
                  endcase
               end
            end
            StMul: begin
               prod_d = prod_step;
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CntW'(MulSteps - 1)) begin
                  hi_d    = prod_res[2*WIDTH-1:WIDTH];
                  lo_d    = prod_res[WIDTH-1:0];
                  state_d = StDone;
               end
            end
            StDiv: begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == CntW'(WIDTH - 1)) begin
                  lo_d    = quo_res;
                  hi_d    = rem_res;
                  state_d = StDone;
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         hi_q      <= '0;
         lo_q      <= '0;
         mcand_q   <= '0;
         prod_q    <= '0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         dbz_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         mcand_q   <= mcand_d;
         prod_q    <= prod_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         dbz_q     <= dbz_d;
         cnt_q     <= cnt_d;
      end
   end

   assign md.busy_o        = (state_q == StMul) || (state_q == StDiv);
   assign md.done_o        = (state_q == StDone);
   assign md.div_by_zero_o = (state_q == StDone) && dbz_q;
   assign md.hi_o          = hi_q;
   assign md.lo_o          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: driver pushes model results, negedge monitor pops on done_o.
module tb_muldiv_unit;
   import muldiv_pkg::*;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dbz;
      int          cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   total;
   int   bad;
   logic [31:0] m_hi;
   logic [31:0] m_lo;
   exp_t sbq[$];
   exp_t mon_e;

   muldiv_if #(.WIDTH(32)) mif ();

   muldiv_unit #(
      .WIDTH         (32),
      .MUL_STEP_BITS (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .md    (mif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(input string name, input logic [63:0] act,
                                 input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Architectural reference: plain 64-bit arithmetic on the sign-interpreted operands.
   function automatic void model(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                                 output exp_t e, output int lat);
      longint      sa;
      longint      sb;
      logic [63:0] p;
      sa    = longint'($signed(a));
      sb    = longint'($signed(b));
      e.dbz = 1'b0;
      lat   = 1;
      case (op)
         MdOpMthi: m_hi = a;
         MdOpMtlo: m_lo = a;
         MdOpMult: begin
            p = 64'(sa * sb);
            {m_hi, m_lo} = p;
            lat = 17;
         end
         MdOpMultu: begin
            p = {32'd0, a} * {32'd0, b};
            {m_hi, m_lo} = p;
            lat = 17;
         end
         MdOpDiv, MdOpDivu: begin
            if (b == 32'd0) begin
               e.dbz = 1'b1;
            end else if (op == MdOpDiv) begin
               m_lo = 32'(sa / sb);
               m_hi = 32'(sa % sb);
               lat  = 33;
            end else begin
               m_lo = a / b;
               m_hi = a % b;
               lat  = 33;
            end
         end
         default: ;
      endcase
      e.hi = m_hi;
      e.lo = m_lo;
   endfunction

   always @(negedge clk) begin
      if (rst_n && mif.done_o) begin
         if (sbq.size() == 0) begin
            check("spurious_done", 64'd1, 64'd0);
         end else begin
            mon_e = sbq.pop_front();
            check("hi", 64'(mif.hi_o), 64'(mon_e.hi));
            check("lo", 64'(mif.lo_o), 64'(mon_e.lo));
            check("div_by_zero", 64'(mif.div_by_zero_o), 64'(mon_e.dbz));
            check("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            check("busy_at_done", 64'(mif.busy_o), 64'd0);
         end
      end
   end

   task automatic run_op(input md_op_t op, input logic [31:0] a, input logic [31:0] b,
                         input bit poke);
      exp_t e;
      int   lat;
      int   n;
      int   busy_n;
      @(negedge clk);
      mif.start_i = 1'b1;
      mif.op_i    = op;
      mif.src_a_i = a;
      mif.src_b_i = b;
      model(op, a, b, e, lat);
      e.cyc = cyc + lat;
      sbq.push_back(e);
      @(negedge clk);
      mif.start_i = 1'b0;
      n      = 0;
      busy_n = 0;
      while (!mif.done_o && n < 60) begin
         if (mif.busy_o) busy_n++;
         if (poke && n == 4) begin
            mif.start_i = 1'b1;
            mif.op_i    = MdOpMtlo;
            mif.src_a_i = $urandom;
         end else begin
            mif.start_i = 1'b0;
         end
         @(negedge clk);
         n++;
      end
      mif.start_i = 1'b0;
      check("done_seen", 64'(mif.done_o), 64'd1);
      check("busy_cycles", 64'(busy_n), 64'(lat - 1));
   endtask

   task automatic pulse_idle(input md_op_t op, input logic flush);
      @(negedge clk);
      mif.start_i = 1'b1;
      mif.flush_i = flush;
      mif.op_i    = op;
      mif.src_a_i = $urandom;
      mif.src_b_i = $urandom | 32'd1;
      @(negedge clk);
      mif.start_i = 1'b0;
      mif.flush_i = 1'b0;
      check("idle_busy", 64'(mif.busy_o), 64'd0);
      check("idle_done", 64'(mif.done_o), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      md_op_t      op;
      logic [31:0] a;
      logic [31:0] b;
      int          r;
      cyc         = 0;
      total       = 0;
      bad         = 0;
      m_hi        = '0;
      m_lo        = '0;
      rst_n       = 1'b0;
      mif.start_i = 1'b0;
      mif.flush_i = 1'b0;
      mif.op_i    = '0;
      mif.src_a_i = '0;
      mif.src_b_i = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      check("rst_hi", 64'(mif.hi_o), 64'd0);
      check("rst_lo", 64'(mif.lo_o), 64'd0);
      check("rst_busy", 64'(mif.busy_o), 64'd0);
      check("rst_done", 64'(mif.done_o), 64'd0);
      check("rst_dbz", 64'(mif.div_by_zero_o), 64'd0);

      run_op(MdOpMult, 32'hFFFF_FFFE, 32'd3, 1'b0);
      check("mult_hi", 64'(mif.hi_o), 64'hFFFF_FFFF);
      check("mult_lo", 64'(mif.lo_o), 64'hFFFF_FFFA);
      run_op(MdOpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      check("multu_hi", 64'(mif.hi_o), 64'hFFFF_FFFE);
      check("multu_lo", 64'(mif.lo_o), 64'h0000_0001);
      run_op(MdOpDiv, 32'hFFFF_FFF9, 32'd2, 1'b0);
      check("div_lo", 64'(mif.lo_o), 64'hFFFF_FFFD);
      check("div_hi", 64'(mif.hi_o), 64'hFFFF_FFFF);
      run_op(MdOpDivu, 32'd7, 32'd2, 1'b0);
      check("divu_lo", 64'(mif.lo_o), 64'd3);
      check("divu_hi", 64'(mif.hi_o), 64'd1);
      run_op(MdOpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      check("min_lo", 64'(mif.lo_o), 64'h8000_0000);
      check("min_hi", 64'(mif.hi_o), 64'd0);
      run_op(MdOpDiv, 32'd5, 32'd0, 1'b0);
      check("dbz_flag", 64'(mif.div_by_zero_o), 64'd1);
      check("dbz_lo_kept", 64'(mif.lo_o), 64'h8000_0000);

      // Flush mid-divide: nothing commits, HI keeps the MTHI value.
      run_op(MdOpMthi, 32'h0000_1234, 32'd0, 1'b0);
      @(negedge clk);
      mif.start_i = 1'b1;
      mif.op_i    = MdOpDiv;
      mif.src_a_i = 32'd100;
      mif.src_b_i = 32'd3;
      @(negedge clk);
      mif.start_i = 1'b0;
      repeat (8) @(negedge clk);
      mif.flush_i = 1'b1;
      @(negedge clk);
      mif.flush_i = 1'b0;
      check("flush_busy", 64'(mif.busy_o), 64'd0);
      repeat (40) @(negedge clk);
      check("flush_hi", 64'(mif.hi_o), 64'h0000_1234);

      // Start during MULT is ignored.
      run_op(MdOpMult, 32'd1000, 32'hFFFF_FF00, 1'b1);

      // Reset mid-multiply clears HI/LO.
      @(negedge clk);
      mif.start_i = 1'b1;
      mif.op_i    = MdOpMultu;
      mif.src_a_i = 32'd77;
      mif.src_b_i = 32'd99;
      @(negedge clk);
      mif.start_i = 1'b0;
      repeat (6) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      m_hi  = '0;
      m_lo  = '0;
      check("midrst_hi", 64'(mif.hi_o), 64'd0);
      check("midrst_lo", 64'(mif.lo_o), 64'd0);
      check("midrst_busy", 64'(mif.busy_o), 64'd0);
      repeat (20) @(negedge clk);

      pulse_idle(MdOpDiv, 1'b1);
      pulse_idle(MdOpMthi, 1'b1);
      pulse_idle(3'd0, 1'b0);
      pulse_idle(3'd7, 1'b0);

      for (int i = 0; i < 40; i++) begin
         r  = $urandom_range(0, 7);
         op = md_op_t'(r);
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 9) == 0) begin
            a = 32'h8000_0000;
            b = 32'hFFFF_FFFF;
         end
         if (op == 3'd0 || op == 3'd7) begin
            pulse_idle(op, 1'b0);
         end else begin
            run_op(op, a, b, 1'b0);
         end
      end

      repeat (3) @(negedge clk);
      check("scoreboard_empty", 64'(sbq.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
